mux_rr_fifo_nx: RTL and testbench
=================================

# mux_rr_fifo_nx

Parametrised N-channel buffered multiplexer for the PCIe physical-layer datapath. It is the next generation of the 2-input, 8-bit mux-with-memory. Each input channel writes into its own synchronous FIFO. An arbiter, either round-robin or fixed-priority, drains the FIFOs into one registered output stage with valid/ready back-pressure. Per-channel full and sticky overflow flags are reported to the link-control logic.

## Interface
Parameters:
- WIDTH, 8: data word width in bits.
- CHANNELS, 2: number of input channels, range 2–8.
- DEPTH, 4: words per channel FIFO; power of two, ≥2.
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority (channel 0 highest).

Ports:
- clk  in  1  single clock; all state updates on its posedge.
- Reset_L  in  1  asynchronous, active-low reset.
- data_in  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- valid_in  in  CHANNELS  push strobe per channel.
- ready_in  in  1  downstream accepts data_out this cycle.
- data_out  out  WIDTH  selected word.
- outValid  out  1  data_out holds a valid word.
- out_chan  out  $clog2(CHANNELS)  source channel of data_out.
- full  out  CHANNELS  FIFO c holds DEPTH words.
- overflow  out  CHANNELS  sticky; set when a push hits a full FIFO.

## Operation
Reset:
- Reset_L low forces, immediately and asynchronously, data_out=0, outValid=0, out_chan=0, full=0, overflow=0.
- All FIFO pointers and counts go to 0, and the round-robin pointer goes to 0.
- Reset mid-operation discards all buffered words; none reappear after release.

Push:
- valid_in[c]=1 at an edge writes data_in[c] into FIFO c when its registered count < DEPTH.
- When the count is DEPTH, the word is dropped and overflow[c] is set. It stays set until reset, even if a pop happens in the same cycle.
- A push and a pop on the same FIFO in one edge are both performed; the count is unchanged.

Output stage:
- load = ~outValid | ready_in.
- On load, the arbiter picks a non-empty FIFO, pops its head into data_out, sets out_chan, and sets outValid=1.
- If no FIFO is non-empty on load, outValid goes to 0, and data_out and out_chan keep their last values.
- If outValid=1 and ready_in=0, data_out, out_chan and outValid hold, and no FIFO pops.

Arbitration:
- Round-robin: the grant goes to the first non-empty channel scanning ptr, ptr+1, … with modulo-CHANNELS wrap. On a grant, ptr becomes (grant+1) mod CHANNELS; otherwise ptr holds.
- Fixed priority: the grant goes to the lowest-index non-empty channel.
- Emptiness is judged on registered counts, so a word pushed at the same edge is not yet eligible.

Width rules:
- FIFO pointers are $clog2(DEPTH) bits and wrap naturally.
- Counts are $clog2(DEPTH)+1 bits.
- full[c] = (count == DEPTH), registered with the count.

## Timing
- Latency: a word pushed at edge k appears on data_out after edge k+1 at the earliest, if its channel wins arbitration and load=1.
- Throughput: one word per cycle out when ready_in is held at 1.
- full and overflow update at the same edge as the causing push.
- Only the asynchronous reset affects outputs between edges.

## Structure
- Package mux_rr_pkg holds the ARB_RR/ARB_FIXED constants and a function clog2_min1 for channel-index width.
- One sub-module, fifo_canal: a synchronous FIFO with WIDTH and DEPTH parameters. Ports are clk, Reset_L, push, pop, din, dout (head, combinational), count, full, and overflow.
- The top generates CHANNELS instances of fifo_canal and contains the arbiter, the round-robin pointer and the output register.

## Test plan
Defaults for all scenarios are WIDTH=8, CHANNELS=2, DEPTH=4.
- **Reset:** Reset_L=0 with valid_in=2'b11 toggling → data_out=0x00, outValid=0, full=0, overflow=0 throughout, with no dependency on clk.
- **Round-robin:** ARB_MODE=0, ready_in=1. Push ch0 0x00–0x03 and ch1 0x03–0x06 on 4 consecutive edges → data_out sequence 00,03,01,04,02,05,03,06 with out_chan alternating 0,1. outValid is continuous for 8 cycles, then 0; overflow=0.
- **Overflow:** ready_in=0. Push 0x10–0x15 on ch0 over 6 edges → data_out=0x10 held, full[0]=1, 0x15 dropped, overflow[0]=1. Then set ready_in=1 → 0x10–0x14 output in order, then outValid=0, with overflow[0] still 1.
- **Fixed priority:** ARB_MODE=1. Preload ch0 with 0xA0–0xA3 and ch1 with 0xB0–0xB1, then set ready_in=1 → A0,A1,A2,A3,B0,B1.
- **Stall:** outValid=1 with data_out=0x42, ready_in=0 for 3 cycles while both channels push → data_out=0x42 and out_chan are stable. The next output after ready_in=1 follows round-robin order.
- **Mid-operation reset:** both FIFOs at count 3, pulse Reset_L low for half a cycle → outputs clear immediately. After release with no pushes, outValid stays 0 for 10 cycles.

Source files
------------

// File: rtl/mux_rr_fifo_nx_pkg.sv
// Shared constants and helpers for the N-channel buffered output multiplexer.
package mux_rr_pkg;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    // Index width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_rr_fifo_nx_fifo.sv
// Per-channel synchronous FIFO with combinational head, registered full flag
// and a sticky overflow flag for pushes that hit a full buffer.
module fifo_canal #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     Reset_L,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNTW-1:0]  count_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != DEPTH_C);
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge Reset_L) begin
        if (!Reset_L) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_C);
            // Judged on the registered count: a same-edge pop does not rescue the push.
            if (push && (count == DEPTH_C)) overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/mux_rr_fifo_nx.sv
// N-channel buffered multiplexer: per-channel FIFOs drained by a round-robin
// or fixed-priority arbiter into a registered valid/ready output stage.
module mux_rr_fifo_nx
    import mux_rr_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ARB_MODE = 0
) (
    input  logic                          clk,
    input  logic                          Reset_L,
    input  logic [CHANNELS*WIDTH-1:0]     data_in,
    input  logic [CHANNELS-1:0]           valid_in,
    input  logic                          ready_in,
    output logic [WIDTH-1:0]              data_out,
    output logic                          outValid,
    output logic [$clog2(CHANNELS)-1:0]   out_chan,
    output logic [CHANNELS-1:0]           full,
    output logic [CHANNELS-1:0]           overflow
);

    localparam int unsigned CW   = clog2_min1(CHANNELS);
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;

    logic [CNTW-1:0]     counts [CHANNELS];
    logic [WIDTH-1:0]    heads  [CHANNELS];
    logic [CHANNELS-1:0] nonempty;
    logic [CHANNELS-1:0] pop;
    logic [CW-1:0]       rr_ptr;
    logic [CW-1:0]       grant;
    logic                grant_valid;
    logic                load;

    assign load = ~outValid | ready_in;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        fifo_canal #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk      (clk),
            .Reset_L  (Reset_L),
            .push     (valid_in[c]),
            .pop      (pop[c]),
            .din      (data_in[c*WIDTH +: WIDTH]),
            .dout     (heads[c]),
            .count    (counts[c]),
            .full     (full[c]),
            .overflow (overflow[c])
        );

        assign nonempty[c] = (counts[c] != '0);
        assign pop[c]      = load && grant_valid && (grant == CW'(c));
    end

    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant       = '0;
        idx         = 0;
        if (ARB_MODE == ARB_FIXED) begin
            // Descending scan so the lowest-index requester is written last.
            for (int unsigned i = CHANNELS; i > 0; i--) begin
                if (nonempty[i-1]) begin
                    grant_valid = 1'b1;
                    grant       = CW'(i - 1);
                end
            end
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                idx = (int'(rr_ptr) + i) % CHANNELS;
                if (!grant_valid && nonempty[idx]) begin
                    grant_valid = 1'b1;
                    grant       = CW'(idx);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_L) begin
        if (!Reset_L) begin
            data_out <= '0;
            outValid <= 1'b0;
            out_chan <= '0;
            rr_ptr   <= '0;
        end else if (load) begin
            if (grant_valid) begin
                data_out <= heads[grant];
                out_chan <= grant;
                outValid <= 1'b1;
                if (ARB_MODE == ARB_RR) begin
                    rr_ptr <= (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
                end
            end else begin
                outValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_rr_fifo_nx.sv
// Directed bench for mux_rr_fifo_nx: a round-robin and a fixed-priority
// instance share stimulus; each scenario starts from reset.
module tb_mux_rr_fifo_nx;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned CHANNELS = 2;
    localparam int unsigned DEPTH    = 4;

    logic                      clk;
    logic                      Reset_L;
    logic [CHANNELS*WIDTH-1:0] data_in;
    logic [CHANNELS-1:0]       valid_in;
    logic                      ready_in;

    logic [WIDTH-1:0]    data_out,  data_out_f;
    logic                outValid,  outValid_f;
    logic [0:0]          out_chan,  out_chan_f;
    logic [CHANNELS-1:0] full,      full_f;
    logic [CHANNELS-1:0] overflow,  overflow_f;

    int checks = 0;
    int errors = 0;

    mux_rr_fifo_nx #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH),
        .ARB_MODE (0)
    ) dut_rr (
        .clk      (clk),
        .Reset_L  (Reset_L),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .data_out (data_out),
        .outValid (outValid),
        .out_chan (out_chan),
        .full     (full),
        .overflow (overflow)
    );

    mux_rr_fifo_nx #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .DEPTH    (DEPTH),
        .ARB_MODE (1)
    ) dut_fix (
        .clk      (clk),
        .Reset_L  (Reset_L),
        .data_in  (data_in),
        .valid_in (valid_in),
        .ready_in (ready_in),
        .data_out (data_out_f),
        .outValid (outValid_f),
        .out_chan (out_chan_f),
        .full     (full_f),
        .overflow (overflow_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d1, input logic [7:0] d0);
        valid_in = v;
        data_in  = {d1, d0};
    endtask

    task automatic apply_reset();
        Reset_L  = 1'b0;
        valid_in = '0;
        data_in  = '0;
        ready_in = 1'b0;
        tick();
        Reset_L = 1'b1;
    endtask

    initial begin
        logic [7:0] rr_exp [8];
        logic [7:0] fx_exp [6];
        rr_exp = '{8'h00, 8'h03, 8'h01, 8'h04, 8'h02, 8'h05, 8'h03, 8'h06};
        fx_exp = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB1};

        // Reset held with pushes toggling, checked between and across edges.
        Reset_L  = 1'b0;
        ready_in = 1'b1;
        drive(2'b00, 8'h00, 8'h00);
        #1;
        for (int i = 0; i < 6; i++) begin
            drive((i % 2 == 0) ? 2'b11 : 2'b00, 8'h5A, 8'hA5);
            #3;
            check("rst_data", 32'(data_out), 32'h00);
            check("rst_valid", 32'(outValid), 32'h0);
            check("rst_full", 32'(full), 32'h0);
            check("rst_ovf", 32'(overflow), 32'h0);
        end
        check("rst_chan", 32'(out_chan), 32'h0);

        // Round-robin interleave with ready held high.
        apply_reset();
        ready_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k < 4) drive(2'b11, 8'(3 + k), 8'(k));
            else       drive(2'b00, 8'h00, 8'h00);
            tick();
            if (k == 0 || k == 9) begin
                check("rr_idle", 32'(outValid), 32'h0);
            end else begin
                check("rr_valid", 32'(outValid), 32'h1);
                check("rr_data", 32'(data_out), 32'(rr_exp[k-1]));
                check("rr_chan", 32'(out_chan), 32'((k - 1) % 2));
            end
        end
        check("rr_ovf", 32'(overflow), 32'h0);

        // Overflow on ch0 while the output is stalled.
        apply_reset();
        for (int k = 0; k < 6; k++) begin
            drive(2'b01, 8'h00, 8'(8'h10 + k));
            tick();
            if (k == 4) begin
                check("ovf_full_at4", 32'(full), 32'h1);
                check("ovf_clear_at4", 32'(overflow), 32'h0);
            end
        end
        check("ovf_hold_data", 32'(data_out), 32'h10);
        check("ovf_hold_valid", 32'(outValid), 32'h1);
        check("ovf_full", 32'(full), 32'h1);
        check("ovf_flag", 32'(overflow), 32'h1);
        drive(2'b00, 8'h00, 8'h00);
        ready_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k < 4) begin
                check("ovf_drain", 32'(data_out), 32'(8'h11 + k));
                check("ovf_drain_v", 32'(outValid), 32'h1);
            end else begin
                check("ovf_empty", 32'(outValid), 32'h0);
            end
            if (k == 0) check("ovf_full_drop", 32'(full), 32'h0);
        end
        check("ovf_sticky", 32'(overflow), 32'h1);

        // Fixed priority: ch0 drains fully before ch1.
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive((k < 2) ? 2'b11 : 2'b01, 8'(8'hB0 + k), 8'(8'hA0 + k));
            tick();
        end
        drive(2'b00, 8'h00, 8'h00);
        check("fx_first", 32'(data_out_f), 32'(fx_exp[0]));
        check("fx_first_chan", 32'(out_chan_f), 32'h0);
        ready_in = 1'b1;
        for (int k = 1; k < 7; k++) begin
            tick();
            if (k < 6) begin
                check("fx_data", 32'(data_out_f), 32'(fx_exp[k]));
                check("fx_chan", 32'(out_chan_f), (k < 4) ? 32'h0 : 32'h1);
            end else begin
                check("fx_empty", 32'(outValid_f), 32'h0);
            end
        end

        // Stall: 0x42 held while both channels push, then RR order resumes.
        apply_reset();
        drive(2'b01, 8'h00, 8'h42);
        tick();
        drive(2'b00, 8'h00, 8'h00);
        tick();
        check("st_load", 32'(data_out), 32'h42);
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, 8'(8'h60 + k), 8'(8'h50 + k));
            tick();
            check("st_data", 32'(data_out), 32'h42);
            check("st_chan", 32'(out_chan), 32'h0);
            check("st_valid", 32'(outValid), 32'h1);
        end
        drive(2'b00, 8'h00, 8'h00);
        ready_in = 1'b1;
        tick();
        check("st_next0", 32'({out_chan, data_out}), 32'h160);
        tick();
        check("st_next1", 32'({out_chan, data_out}), 32'h050);
        tick();
        check("st_next2", 32'({out_chan, data_out}), 32'h161);

        // Mid-operation reset discards buffered words.
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive((k < 3) ? 2'b11 : 2'b01, 8'(8'h70 + k), 8'(8'h30 + k));
            tick();
        end
        drive(2'b00, 8'h00, 8'h00);
        check("mr_pre_valid", 32'(outValid), 32'h1);
        check("mr_pre_full", 32'(full), 32'h0);
        Reset_L = 1'b0;
        #1;
        check("mr_data", 32'(data_out), 32'h00);
        check("mr_valid", 32'(outValid), 32'h0);
        #3;
        Reset_L  = 1'b1;
        ready_in = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("mr_after", 32'(outValid), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
